// File: rtl/isa_pkg.sv
// Shared ISA definitions: field widths, the packed instruction layout the
// instruction memory decodes, and the loader state encoding.
package isa_pkg;

   localparam int OP_W    = 3;
   localparam int REG_W   = 3;
   localparam int INSTR_W = OP_W + 2 * REG_W;

   // Field order matches the bit layout of a stored word: op [8:6], r1 [5:3], r2 [2:0].
   typedef struct packed {
      logic [OP_W-1:0]  op;
      logic [REG_W-1:0] r1;
      logic [REG_W-1:0] r2;
   } instr_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2,
      S_ERR  = 2'd3
   } loader_state_t;

endpackage

// File: rtl/instr_loader_if.sv
// Instruction stream (valid/ready) plus instruction-memory write port.
// The loader takes the slave side; the boot harness takes the master side.
interface instr_loader_if #(
   parameter int PC_BITS = 12
) ();
   import isa_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   logic [OP_W-1:0]      in_op;
   logic [REG_W-1:0]     in_r1;
   logic [REG_W-1:0]     in_r2;
   logic                 in_last;
   logic                 wr_en;
   logic [PC_BITS-1:0]   wr_addr;
   logic [INSTR_W-1:0]   wr_data;

   modport slave (
      input  in_valid, in_op, in_r1, in_r2, in_last,
      output in_ready, wr_en, wr_addr, wr_data
   );

   modport master (
      output in_valid, in_op, in_r1, in_r2, in_last,
      input  in_ready, wr_en, wr_addr, wr_data
   );

endinterface

// File: rtl/instr_pack.sv
// Combinational field-to-word packer, reusable by the harness and models.
module instr_pack
   import isa_pkg::*;
(
   input  logic [OP_W-1:0]  i_op,
   input  logic [REG_W-1:0] i_r1,
   input  logic [REG_W-1:0] i_r2,
   output instr_t           o_word
);

   assign o_word = {i_op, i_r1, i_r2};

endmodule

// File: rtl/instr_loader.sv
// Program loader: packs streamed instruction fields and writes them to
// sequential memory addresses. Optional feature macro: INSTR_LOADER_CHECKSUM_EN.
module instr_loader
   import isa_pkg::*;
#(
   parameter int PC_BITS = 12
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               abort,
   instr_loader_if.slave      bus,
   output logic               busy,
   output logic               done,
   output logic               error,
   output logic [PC_BITS:0]   word_count
`ifdef INSTR_LOADER_CHECKSUM_EN
   ,
   input  logic [INSTR_W-1:0] exp_checksum,
   output logic [INSTR_W-1:0] checksum
`endif
);

   localparam logic [PC_BITS-1:0] LAST_ADDR = '1;

   loader_state_t        r_state;
   logic [PC_BITS-1:0]   r_addr;
   logic [PC_BITS:0]     r_wordCount;
   logic                 r_wrEn;
   logic [PC_BITS-1:0]   r_wrAddr;
   logic [INSTR_W-1:0]   r_wrData;

   instr_t               w_word;
   logic                 w_accept;
   logic                 w_restart;
   logic                 w_lastOk;

   instr_pack u_pack (
      .i_op   (bus.in_op),
      .i_r1   (bus.in_r1),
      .i_r2   (bus.in_r2),
      .o_word (w_word)
   );

   // Abort wins over everything, so a beat alongside it is never taken.
   assign w_accept  = (r_state == S_LOAD) && bus.in_valid && !abort;
   assign w_restart = (r_state != S_LOAD) && start && !abort;

`ifdef INSTR_LOADER_CHECKSUM_EN
   logic [INSTR_W-1:0] r_checksum;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_checksum <= '0;
      end else if (w_restart) begin
         r_checksum <= '0;
      end else if (w_accept) begin
         r_checksum <= r_checksum ^ w_word;
      end
   end

   assign checksum = r_checksum;
   // The final word must be folded in before comparing against the expected value.
   assign w_lastOk = (exp_checksum == (r_checksum ^ w_word));
`else
   assign w_lastOk = 1'b1;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_wordCount <= '0;
         r_wrEn      <= 1'b0;
         r_wrAddr    <= '0;
         r_wrData    <= '0;
      end else begin
         r_wrEn <= 1'b0;
         if (abort) begin
            r_state <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE, S_DONE, S_ERR: begin
                  if (start) begin
                     r_state     <= S_LOAD;
                     r_addr      <= '0;
                     r_wordCount <= '0;
                  end
               end
               S_LOAD: begin
                  if (bus.in_valid) begin
                     r_wrEn      <= 1'b1;
                     r_wrAddr    <= r_addr;
                     r_wrData    <= w_word;
                     r_addr      <= r_addr + PC_BITS'(1);
                     r_wordCount <= r_wordCount + (PC_BITS + 1)'(1);
                     // A last beat at the top address still completes normally.
                     if (bus.in_last) begin
                        r_state <= w_lastOk ? S_DONE : S_ERR;
                     end else if (r_addr == LAST_ADDR) begin
                        r_state <= S_ERR;
                     end
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.in_ready = (r_state == S_LOAD);
   assign bus.wr_en    = r_wrEn;
   assign bus.wr_addr  = r_wrAddr;
   assign bus.wr_data  = r_wrData;
   assign busy         = (r_state == S_LOAD);
   assign done         = (r_state == S_DONE);
   assign error        = (r_state == S_ERR);
   assign word_count   = r_wordCount;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a 12-bit-address loader for normal
// sessions and a 2-bit-address loader for overflow boundaries.
module tb_instr_loader;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic        abort;
   logic        busy;
   logic        done;
   logic        error;
   logic [12:0] word_count;

   logic        startS;
   logic        abortS;
   logic        busyS;
   logic        doneS;
   logic        errorS;
   logic [2:0]  word_countS;

   int checks   = 0;
   int failures = 0;

   instr_loader_if #(.PC_BITS(12)) bus  ();
   instr_loader_if #(.PC_BITS(2))  busS ();

`ifdef INSTR_LOADER_CHECKSUM_EN
   logic [8:0] exp_checksum;
   logic [8:0] checksum;
   logic [8:0] exp_checksumS;
   logic [8:0] checksumS;
`endif

   instr_loader #(.PC_BITS(12)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .abort        (abort),
      .bus          (bus),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .word_count   (word_count)
`ifdef INSTR_LOADER_CHECKSUM_EN
      ,
      .exp_checksum (exp_checksum),
      .checksum     (checksum)
`endif
   );

   instr_loader #(.PC_BITS(2)) dutS (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (startS),
      .abort        (abortS),
      .bus          (busS),
      .busy         (busyS),
      .done         (doneS),
      .error        (errorS),
      .word_count   (word_countS)
`ifdef INSTR_LOADER_CHECKSUM_EN
      ,
      .exp_checksum (exp_checksumS),
      .checksum     (checksumS)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Advances one clock and leaves time 1ns past the edge for sampling/driving.
   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input logic [2:0] op,
                                input logic [2:0] r1, input logic [2:0] r2,
                                input logic last);
      bus.in_valid = valid;
      bus.in_op    = op;
      bus.in_r1    = r1;
      bus.in_r2    = r2;
      bus.in_last  = last;
   endtask

   initial begin
      logic [11:0] expAddr;

      reset_n  = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      startS   = 1'b0;
      abortS   = 1'b0;
      applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
      busS.in_valid = 1'b0;
      busS.in_op    = 3'd0;
      busS.in_r1    = 3'd0;
      busS.in_r2    = 3'd0;
      busS.in_last  = 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      exp_checksum  = 9'h000;
      exp_checksumS = 9'h000;
`endif

      // Reset values
      #2;
      checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("rst_wr_en", 32'(bus.wr_en), 32'd0);
      checkOutput("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
      checkOutput("rst_wr_data", 32'(bus.wr_data), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_error", 32'(error), 32'd0);
      checkOutput("rst_word_count", 32'(word_count), 32'd0);
      stepCycle();
      reset_n = 1'b1;

      // Beat before start is dropped
      applyStimulus(1'b1, 3'd3, 3'd3, 3'd3, 1'b0);
      stepCycle();
      checkOutput("idle_drop_wr_en", 32'(bus.wr_en), 32'd0);
      checkOutput("idle_in_ready", 32'(bus.in_ready), 32'd0);

      // Basic three-beat session
      applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
      start = 1'b1;
      stepCycle();
      start = 1'b0;
      checkOutput("start_busy", 32'(busy), 32'd1);
      checkOutput("start_in_ready", 32'(bus.in_ready), 32'd1);
      applyStimulus(1'b1, 3'd5, 3'd2, 3'd7, 1'b0);
      stepCycle();
      checkOutput("b0_wr_en", 32'(bus.wr_en), 32'd1);
      checkOutput("b0_wr_addr", 32'(bus.wr_addr), 32'd0);
      checkOutput("b0_wr_data", 32'(bus.wr_data), 32'h157);
      applyStimulus(1'b1, 3'd1, 3'd0, 3'd0, 1'b0);
      stepCycle();
      checkOutput("b1_wr_addr", 32'(bus.wr_addr), 32'd1);
      checkOutput("b1_wr_data", 32'(bus.wr_data), 32'h040);
      applyStimulus(1'b1, 3'd7, 3'd7, 3'd7, 1'b1);
      stepCycle();
      checkOutput("b2_wr_en", 32'(bus.wr_en), 32'd1);
      checkOutput("b2_wr_addr", 32'(bus.wr_addr), 32'd2);
      checkOutput("b2_wr_data", 32'(bus.wr_data), 32'h1FF);
      checkOutput("b2_done", 32'(done), 32'd1);
      checkOutput("b2_busy", 32'(busy), 32'd0);
      checkOutput("b2_word_count", 32'(word_count), 32'd3);
      checkOutput("b2_in_ready", 32'(bus.in_ready), 32'd0);
      applyStimulus(1'b1, 3'd2, 3'd2, 3'd2, 1'b0);
      stepCycle();
      checkOutput("done_drop_wr_en", 32'(bus.wr_en), 32'd0);
      checkOutput("done_sticky", 32'(done), 32'd1);

      // Valid toggling: writes only on accepted cycles, contiguous addresses
      applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
      start = 1'b1;
      stepCycle();
      start = 1'b0;
      checkOutput("tog_done_cleared", 32'(done), 32'd0);
      expAddr = 12'd0;
      for (int i = 0; i < 7; i++) begin
         applyStimulus((i % 2) == 0, 3'(i), 3'(i + 1), 3'(6 - i), i == 6);
         stepCycle();
         if ((i % 2) == 0) begin
            checkOutput($sformatf("tog%0d_wr_en", i), 32'(bus.wr_en), 32'd1);
            checkOutput($sformatf("tog%0d_wr_addr", i), 32'(bus.wr_addr), 32'(expAddr));
            checkOutput($sformatf("tog%0d_wr_data", i), 32'(bus.wr_data),
                        32'({3'(i), 3'(i + 1), 3'(6 - i)}));
            expAddr = expAddr + 12'd1;
         end else begin
            checkOutput($sformatf("tog%0d_wr_en", i), 32'(bus.wr_en), 32'd0);
         end
      end
      checkOutput("tog_done", 32'(done), 32'd1);
      checkOutput("tog_word_count", 32'(word_count), 32'd4);

      // Abort during the second beat
      applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
      start = 1'b1;
      stepCycle();
      start = 1'b0;
      applyStimulus(1'b1, 3'd4, 3'd1, 3'd2, 1'b0);
      stepCycle();
      checkOutput("ab_b0_wr_en", 32'(bus.wr_en), 32'd1);
      applyStimulus(1'b1, 3'd6, 3'd5, 3'd4, 1'b0);
      abort = 1'b1;
      stepCycle();
      abort = 1'b0;
      checkOutput("ab_wr_en", 32'(bus.wr_en), 32'd0);
      checkOutput("ab_busy", 32'(busy), 32'd0);
      checkOutput("ab_in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("ab_word_count", 32'(word_count), 32'd1);
      checkOutput("ab_error", 32'(error), 32'd0);
      applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
      start = 1'b1;
      stepCycle();
      start = 1'b0;
      checkOutput("ab_restart_count", 32'(word_count), 32'd0);
      checkOutput("ab_restart_busy", 32'(busy), 32'd1);
      applyStimulus(1'b1, 3'd1, 3'd1, 3'd1, 1'b1);
      stepCycle();
      checkOutput("ab2_done", 32'(done), 32'd1);
      applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
      abort = 1'b1;
      stepCycle();
      abort = 1'b0;
      checkOutput("ab2_done_cleared", 32'(done), 32'd0);
      checkOutput("ab2_count_kept", 32'(word_count), 32'd1);

      // Reset asserted mid-session
      start = 1'b1;
      stepCycle();
      start = 1'b0;
      applyStimulus(1'b1, 3'd2, 3'd3, 3'd4, 1'b0);
      stepCycle();
      checkOutput("mr_wr_en", 32'(bus.wr_en), 32'd1);
      reset_n = 1'b0;
      #1;
      checkOutput("mr_async_wr_en", 32'(bus.wr_en), 32'd0);
      checkOutput("mr_async_busy", 32'(busy), 32'd0);
      checkOutput("mr_async_in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("mr_async_word_count", 32'(word_count), 32'd0);
      checkOutput("mr_async_wr_data", 32'(bus.wr_data), 32'd0);
      stepCycle();
      reset_n = 1'b1;
      stepCycle();
      checkOutput("mr_no_start_wr_en", 32'(bus.wr_en), 32'd0);
      checkOutput("mr_no_start_count", 32'(word_count), 32'd0);
      applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);

      // Overflow on the 2-bit loader: 4 writes, error, 5th beat refused
      startS = 1'b1;
      stepCycle();
      startS = 1'b0;
      busS.in_valid = 1'b1;
      busS.in_last  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         busS.in_op = 3'(i);
         busS.in_r1 = 3'd1;
         busS.in_r2 = 3'd2;
         stepCycle();
         if (i < 4) begin
            checkOutput($sformatf("ovf%0d_wr_en", i), 32'(busS.wr_en), 32'd1);
            checkOutput($sformatf("ovf%0d_wr_addr", i), 32'(busS.wr_addr), 32'(i));
         end else begin
            checkOutput("ovf4_wr_en", 32'(busS.wr_en), 32'd0);
         end
         if (i == 2) checkOutput("ovf2_error", 32'(errorS), 32'd0);
         if (i == 3) begin
            checkOutput("ovf3_error", 32'(errorS), 32'd1);
            checkOutput("ovf3_in_ready", 32'(busS.in_ready), 32'd0);
            checkOutput("ovf3_busy", 32'(busyS), 32'd0);
            checkOutput("ovf3_word_count", 32'(word_countS), 32'd4);
         end
      end

      // Last beat landing exactly on the top address completes normally
      busS.in_valid = 1'b0;
      startS = 1'b1;
      stepCycle();
      startS = 1'b0;
      checkOutput("top_error_cleared", 32'(errorS), 32'd0);
      checkOutput("top_count_cleared", 32'(word_countS), 32'd0);
      busS.in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         busS.in_last = (i == 3);
         stepCycle();
      end
      busS.in_valid = 1'b0;
      busS.in_last  = 1'b0;
      checkOutput("top_wr_addr", 32'(busS.wr_addr), 32'd3);
      checkOutput("top_done", 32'(doneS), 32'd1);
      checkOutput("top_error", 32'(errorS), 32'd0);

`ifdef INSTR_LOADER_CHECKSUM_EN
      // Checksum match and mismatch
      exp_checksum = 9'h117;
      start = 1'b1;
      stepCycle();
      start = 1'b0;
      applyStimulus(1'b1, 3'd5, 3'd2, 3'd7, 1'b0);
      stepCycle();
      applyStimulus(1'b1, 3'd1, 3'd0, 3'd0, 1'b1);
      stepCycle();
      applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
      checkOutput("cks_ok_done", 32'(done), 32'd1);
      checkOutput("cks_ok_value", 32'(checksum), 32'h117);
      exp_checksum = 9'h000;
      start = 1'b1;
      stepCycle();
      start = 1'b0;
      checkOutput("cks_cleared", 32'(checksum), 32'h000);
      applyStimulus(1'b1, 3'd5, 3'd2, 3'd7, 1'b0);
      stepCycle();
      applyStimulus(1'b1, 3'd1, 3'd0, 3'd0, 1'b1);
      stepCycle();
      applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
      checkOutput("cks_bad_error", 32'(error), 32'd1);
      checkOutput("cks_bad_done", 32'(done), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
